gray_codec_pipe: RTL and testbench
==================================

Name: gray_codec_pipe

Overview:
Parametrised, pipelined, multi-mode Gray/binary code converter with a valid/ready stream interface. It is the registered successor to the combinational Gray-to-binary/binary-to-Gray converter, and adds:
- a Gray-increment mode, so the block can serve as a CDC FIFO pointer generator;
- a configurable pipeline depth with backpressure;
- a wrap flag and a flush.

It sits between pointer/counter logic and synchroniser or datapath consumers.

Parameters:
N, 8, data width in bits (N >= 2)
STAGES, 2, pipeline register depth (STAGES >= 1); input-to-output latency in cycles

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset; asynchronous, active-low
flush  in  1  synchronous clear of all in-flight beats
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
in_mode  in  2  00 B2G, 01 G2B, 10 GINC (Gray increment), 11 PASS
in_data  in  N  operand
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts beat
out_data  out  N  result
out_wrap  out  1  GINC result wrapped from all-max to zero
out_mode  out  2  mode the beat was issued with

Behaviour:
- Reset (rst_n low, asynchronous): all stage valids = 0; out_valid = 0, out_data = 0, out_wrap = 0, out_mode = 0; in_ready = 1 once reset is released.
- Transfer: a transfer occurs on a rising edge with valid && ready, on either side.
- Global-stall pipeline:
  - advance = out_ready || !out_valid;
  - in_ready = advance (combinational);
  - when advance, every stage register loads from the previous stage, including valid bits (bubbles propagate; they do not collapse);
  - when !advance, all stages hold.
- Latency: exactly STAGES cycles from acceptance to out_valid with no stall; throughput is 1 beat/cycle.
- Compute: in stage 1, combinational on accepted input. Stages 2..STAGES are pure delay.
  - B2G: d ^ (d >> 1).
  - G2B: prefix XOR from MSB, bit[i] = ^d[N-1:i].
  - GINC: b = G2B(d); r = B2G(b + 1) mod 2^N; wrap = (b == 2^N - 1). Input 2^(N-1) (Gray of all-ones) gives 0 with wrap = 1.
  - PASS: d unchanged.
  - wrap = 0 for every mode except GINC.
- No-beat stages: stage data is don't-care but must be held at its last value (no X propagation); out_data is stable while out_valid && !out_ready (AXI-style hold).
- flush: on the next edge all valids clear, independent of out_ready. in_ready during flush = 1, but a beat offered in the flush cycle is discarded (flush wins).
- Reset mid-stream: all beats lost; out_valid drops immediately (asynchronous).
- in_valid while !in_ready: the beat is not taken; the source must hold it.

Optional Feature:
Macro: GRAY_CODEC_CHECK_EN.
- With the macro defined: extra output port chk_err (1 bit), plus an internal register last_g (N bits) and last_ok (1 bit).
  - On each accepted G2B or GINC beat: if last_ok and popcount(in_data ^ last_g) > 1, then chk_err pulses high for one cycle, aligned with that beat's out_valid.
  - last_g is then updated and last_ok is set.
  - last_ok is cleared by reset and by flush.
  - Identical consecutive inputs are not errors.
- Without the macro: the port, registers and logic are absent.

Decomposition:
- Package gray_codec_pkg:
  - mode typedef (enum logic [1:0]: MODE_B2G, MODE_G2B, MODE_GINC, MODE_PASS);
  - automatic functions bin2gray and gray2bin, parametrised via a width argument or a localparam max width;
  - a stage-payload struct {data, wrap, mode}.
- One sub-module, gray_codec_stage: a single valid + payload register slice with advance and flush. It is instantiated STAGES times via a generate loop; the top-level module holds the compute logic and the checker.

Test Plan (N = 8, STAGES = 2):
- B2G: in_data = 8'hB5, out_ready = 1 -> 2 cycles later out_data = 8'hEF, out_wrap = 0, out_mode = 00.
- G2B: 8'hEF -> 8'hB5. Exhaustive: all 256 values in B2G then G2B back-to-back, one per cycle -> results match the package functions, with no bubbles.
- GINC: 8'hEF -> 8'hED, wrap = 0. Then 8'h80 -> 8'h00, wrap = 1.
- Backpressure: send 4 beats and hold out_ready = 0 for 5 cycles.
  - in_ready = 0 while the pipe is full; out_data is stable throughout;
  - after release, all beats emerge in order, none dropped or duplicated.
- Flush and reset: with 2 beats in flight, assert flush for one cycle -> out_valid = 0 next cycle and those beats are never output. Assert rst_n low mid-stream -> out_valid = 0 asynchronously; after release, the first beat has latency 2.
- GRAY_CODEC_CHECK_EN: G2B sequence 8'h00, 8'h01, 8'h03, 8'h00 -> chk_err = 1 only on the 4th beat (2 bits differ). After a flush, 8'hFF -> chk_err = 0.

Source files
------------

// File: rtl/gray_codec_pkg.sv
// Shared mode encoding, stage metadata and Gray/binary conversion helpers for gray_codec_pipe.
// Helpers operate at MaxW bits; zero-extended narrower operands convert correctly.
package gray_codec_pkg;

   localparam int unsigned MaxW = 64;

   typedef enum logic [1:0] {
      MODE_B2G  = 2'b00,
      MODE_G2B  = 2'b01,
      MODE_GINC = 2'b10,
      MODE_PASS = 2'b11
   } mode_e;

   // Width-independent part of a stage payload; the top adds the N-bit data field.
   typedef struct packed {
      logic  wrap;
      mode_e mode;
   } stage_meta_t;

   function automatic logic [MaxW-1:0] bin2gray(input logic [MaxW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Prefix XOR from the MSB down; zero upper bits leave the low-order result unchanged.
   function automatic logic [MaxW-1:0] gray2bin(input logic [MaxW-1:0] g);
      logic [MaxW-1:0] b;
      b[MaxW-1] = g[MaxW-1];
      for (int i = MaxW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_codec_stage.sv
// One valid + payload register slice of the global-stall pipeline.
// Payload is held (not cleared) on bubbles and on flush so no X ever reaches the output.
module gray_codec_stage #(
   parameter type payload_t = logic
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     flush,
   input  logic     advance,
   input  logic     in_valid,
   input  payload_t in_pl,
   output logic     out_valid,
   output payload_t out_pl
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_pl    <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (advance) begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_pl <= in_pl;
         end
      end
   end

endmodule

// File: rtl/gray_codec_pipe.sv
// Pipelined Gray/binary converter (B2G, G2B, Gray increment, pass) with valid/ready and flush.
// Define GRAY_CODEC_CHECK_EN to add the chk_err Gray-adjacency checker output.
module gray_codec_pipe
   import gray_codec_pkg::*;
#(
   parameter int unsigned N      = 8,
   parameter int unsigned STAGES = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   in_mode,
   input  logic [N-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic         out_wrap,
   output logic [1:0]   out_mode
`ifdef GRAY_CODEC_CHECK_EN
   ,
   output logic         chk_err
`endif
);

   typedef struct packed {
      logic [N-1:0] data;
      stage_meta_t  meta;
`ifdef GRAY_CODEC_CHECK_EN
      logic         chk;
`endif
   } payload_t;

   logic           advance;
   logic [STAGES:0] vld;
   payload_t       pl [STAGES+1];
   mode_e          mode;
   logic [N-1:0]   bin_v;
   logic [N-1:0]   bin_inc;
   logic [N-1:0]   res;
   logic           wrap;

   assign advance  = out_ready | ~out_valid;
   // A beat offered during flush is discarded, so the input side may always report ready.
   assign in_ready = advance | flush;
   assign mode     = mode_e'(in_mode);

   always_comb begin
      bin_v   = N'(gray2bin(MaxW'(in_data)));
      bin_inc = bin_v + N'(1);
      res     = in_data;
      wrap    = 1'b0;
      case (mode)
         MODE_B2G:  res = N'(bin2gray(MaxW'(in_data)));
         MODE_G2B:  res = bin_v;
         MODE_GINC: begin
            res  = N'(bin2gray(MaxW'(bin_inc)));
            wrap = &bin_v;
         end
         default:   res = in_data;
      endcase
   end

`ifdef GRAY_CODEC_CHECK_EN
   logic [N-1:0] last_g_q;
   logic         last_ok_q;
   logic         gray_in;
   logic         chk_d;

   assign gray_in = (mode == MODE_G2B) || (mode == MODE_GINC);
   assign chk_d   = gray_in && last_ok_q && ($countones(in_data ^ last_g_q) > 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_g_q  <= '0;
         last_ok_q <= 1'b0;
      end else if (flush) begin
         last_ok_q <= 1'b0;
      end else if (in_valid && advance && gray_in) begin
         last_g_q  <= in_data;
         last_ok_q <= 1'b1;
      end
   end

   assign pl[0].chk = chk_d;
   assign chk_err   = vld[STAGES] & pl[STAGES].chk;
`endif

   assign vld[0]         = in_valid;
   assign pl[0].data      = res;
   assign pl[0].meta.wrap = wrap;
   assign pl[0].meta.mode = mode;

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      gray_codec_stage #(
         .payload_t(payload_t)
      ) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .flush    (flush),
         .advance  (advance),
         .in_valid (vld[g]),
         .in_pl    (pl[g]),
         .out_valid(vld[g+1]),
         .out_pl   (pl[g+1])
      );
   end

   assign out_valid = vld[STAGES];
   assign out_data  = pl[STAGES].data;
   assign out_wrap  = pl[STAGES].meta.wrap;
   assign out_mode  = pl[STAGES].meta.mode;

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Self-checking bench for gray_codec_pipe (N=8, STAGES=2): vector table plus stall/flush/reset sequences.
module tb_gray_codec_pipe;
   import gray_codec_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_mode;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_wrap;
   logic [1:0] out_mode;
`ifdef GRAY_CODEC_CHECK_EN
   logic       chk_err;
`endif

   gray_codec_pipe #(
      .N     (8),
      .STAGES(2)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_mode  (in_mode),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_wrap (out_wrap),
      .out_mode (out_mode)
`ifdef GRAY_CODEC_CHECK_EN
      ,
      .chk_err  (chk_err)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] mode;
      logic [7:0] din;
      logic [7:0] dout;
      logic       wrap;
   } vec_t;

   vec_t        vecs [14];
   int          tests = 0;
   int          fails = 0;
   logic [10:0] exp_q [$];
   logic        mon_en = 1'b0;
   int          cyc = 0;
   int          mon_cnt = 0;
   int          first_cyc = 0;
   int          last_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Independent reference: shift-and-xor form of the Gray decode.
   function automatic logic [7:0] m_b2g(input logic [7:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [7:0] m_g2b(input logic [7:0] g);
      logic [7:0] b;
      b = g;
      for (int s = 1; s < 8; s++) b = b ^ (g >> s);
      return b;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      in_valid = 1'b1;
      in_mode  = v.mode;
      in_data  = v.din;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check({tag, "_early"}, 32'(out_valid), 32'd0);
      @(negedge clk);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_data"}, 32'(out_data), 32'(v.dout));
      check({tag, "_wrap"}, 32'(out_wrap), 32'(v.wrap));
      check({tag, "_mode"}, 32'(out_mode), 32'(v.mode));
      tick();
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mon_en && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
         end else begin
            check("mon_beat", 32'({out_data, out_wrap, out_mode}), 32'(exp_q.pop_front()));
            if (mon_cnt == 0) first_cyc = cyc;
            last_cyc = cyc;
            mon_cnt++;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] bp [4];
      logic [7:0] held;
      logic       held_ok;
      logic       acc;
      logic       seen;
      int         idx;

      vecs[0]  = '{2'b00, 8'hB5, 8'hEF, 1'b0};
      vecs[1]  = '{2'b01, 8'hEF, 8'hB5, 1'b0};
      vecs[2]  = '{2'b10, 8'hEF, 8'hED, 1'b0};
      vecs[3]  = '{2'b10, 8'h80, 8'h00, 1'b1};
      vecs[4]  = '{2'b11, 8'h3C, 8'h3C, 1'b0};
      vecs[5]  = '{2'b00, 8'hFF, 8'h80, 1'b0};
      vecs[6]  = '{2'b01, 8'h80, 8'hFF, 1'b0};
      vecs[7]  = '{2'b10, 8'h00, 8'h01, 1'b0};
      vecs[8]  = '{2'b10, 8'h01, 8'h03, 1'b0};
      vecs[9]  = '{2'b00, 8'h0F, 8'h08, 1'b0};
      vecs[10] = '{2'b01, 8'h03, 8'h02, 1'b0};
      vecs[11] = '{2'b11, 8'hFF, 8'hFF, 1'b0};
      vecs[12] = '{2'b01, 8'h00, 8'h00, 1'b0};
      vecs[13] = '{2'b10, 8'h03, 8'h02, 1'b0};
      bp[0] = 8'h12; bp[1] = 8'h34; bp[2] = 8'h56; bp[3] = 8'h78;

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_mode = 2'b00; in_data = 8'h00;
      out_ready = 1'b1;
      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_wrap", 32'(out_wrap), 32'd0);
      check("rst_out_mode", 32'(out_mode), 32'd0);
      #5 rst_n = 1'b1;
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd1);

      for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Exhaustive B2G then G2B stream, one beat per cycle, must emerge with no bubbles.
      mon_en = 1'b1; mon_cnt = 0;
      for (int i = 0; i < 512; i++) begin
         in_valid = 1'b1;
         in_mode  = (i < 256) ? 2'b00 : 2'b01;
         in_data  = 8'(i);
         exp_q.push_back({(i < 256) ? m_b2g(8'(i)) : m_g2b(8'(i)), 1'b0, in_mode});
         tick();
      end
      in_valid = 1'b0;
      for (int c = 0; c < 10 && exp_q.size() != 0; c++) tick();
      check("exh_drained", 32'(exp_q.size()), 32'd0);
      check("exh_count", 32'(mon_cnt), 32'd512);
      check("exh_no_bubble", 32'(last_cyc - first_cyc), 32'd511);

      // Backpressure: four beats against five cycles of out_ready low.
      idx = 0; held = 8'h00; held_ok = 1'b0;
      out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'b00; in_data = bp[0];
      for (int c = 0; c < 40 && !(idx == 4 && exp_q.size() == 0); c++) begin
         @(negedge clk);
         if (out_valid && !out_ready) begin
            if (held_ok) check("bp_hold", 32'(out_data), 32'(held));
            held = out_data; held_ok = 1'b1;
         end else begin
            held_ok = 1'b0;
         end
         if (c == 3) check("bp_full_ready", 32'(in_ready), 32'd0);
         acc = in_valid && in_ready;
         tick();
         if (acc) begin
            exp_q.push_back({m_b2g(bp[idx]), 1'b0, 2'b00});
            idx++;
         end
         in_valid = (idx < 4);
         if (idx < 4) in_data = bp[idx];
         if (c == 4) out_ready = 1'b1;
      end
      in_valid = 1'b0;
      check("bp_accepted", 32'(idx), 32'd4);
      check("bp_drained", 32'(exp_q.size()), 32'd0);

      // Flush with the pipe full; the beat offered alongside flush is dropped too.
      out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'b00; in_data = 8'hA1;
      tick();
      in_data = 8'hA2;
      tick();
      check("fl_full_valid", 32'(out_valid), 32'd1);
      in_data = 8'hA3; flush = 1'b1;
      #1 check("fl_in_ready", 32'(in_ready), 32'd1);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check("fl_out_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b1; seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         seen = seen | out_valid;
      end
      check("fl_never_out", 32'(seen), 32'd0);
      tick();

      // Asynchronous reset mid-stream, then first-beat latency after release.
      mon_en = 1'b0;
      in_valid = 1'b1; in_mode = 2'b00; in_data = 8'h11;
      tick();
      in_data = 8'h22;
      tick();
      in_valid = 1'b0;
      check("rs_busy_valid", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rs_async_valid", 32'(out_valid), 32'd0);
      check("rs_async_data", 32'(out_data), 32'd0);
      @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;
      tick();
      exp_q.delete();
      run_vec(vecs[0], "rs_first");

`ifdef GRAY_CODEC_CHECK_EN
      begin
         logic [7:0] cs [4];
         logic       ce [4];
         int         k;
         cs[0] = 8'h00; cs[1] = 8'h01; cs[2] = 8'h03; cs[3] = 8'h00;
         ce[0] = 1'b0;  ce[1] = 1'b0;  ce[2] = 1'b0;  ce[3] = 1'b1;
         flush = 1'b1;
         tick();
         flush = 1'b0;
         k = 0;
         for (int c = 0; c < 8; c++) begin
            in_valid = (c < 4); in_mode = 2'b01; in_data = cs[c % 4];
            @(negedge clk);
            if (out_valid && k < 4) begin
               check($sformatf("chk_seq%0d", k), 32'(chk_err), 32'(ce[k]));
               k++;
            end
            tick();
         end
         in_valid = 1'b0;
         check("chk_seq_count", 32'(k), 32'd4);
         flush = 1'b1;
         tick();
         flush = 1'b0;
         in_valid = 1'b1; in_mode = 2'b01; in_data = 8'hFF;
         tick();
         in_valid = 1'b0;
         @(negedge clk);
         @(negedge clk);
         check("chk_flush_valid", 32'(out_valid), 32'd1);
         check("chk_after_flush", 32'(chk_err), 32'd0);
         tick();
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
